// File: rtl/mem_stage.sv
// MEM stage: resolves the branch and runs data-memory accesses over a req/ack bus.
// Latency: one stall cycle plus N wait cycles per aligned access; upstream is held while stall is high.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        zero,
  input  logic [31:0] AddResultOutput,
  input  logic [31:0] AluResultOutput,
  input  logic [31:0] readData2Output,
  input  logic [4:0]  rdORrtOutput,
  input  logic [1:0]  WBoutput,
  output logic        PCSrc,
  output logic [31:0] branchTarget,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] memReadData,
  output logic [31:0] memAluResult,
  output logic [4:0]  memRd,
  output logic [1:0]  memWB,
  output logic        align_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    rd_q;
  logic [1:0]    wb_q;

  logic access, aligned, last;

  assign access       = memRead | memWrite;
  assign aligned      = (AluResultOutput[1:0] == 2'b00);
  assign last         = (cnt_q == CW'(TIMEOUT - 1));
  assign PCSrc        = branch & zero;
  assign branchTarget = AddResultOutput;

  always_comb begin
    stall = 1'b0;
    if (state_q == IDLE) stall = access & aligned;
    else                 stall = ~dmem_ack & ~last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_q         <= '0;
      wb_q         <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      memReadData  <= '0;
      memAluResult <= '0;
      memRd        <= '0;
      memWB        <= '0;
      align_err    <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      case (state_q)
        IDLE: begin
          memReadData  <= '0;
          memAluResult <= AluResultOutput;
          memRd        <= rdORrtOutput;
          if (access && !aligned) begin
            memWB     <= 2'b00;
            align_err <= 1'b1;
          end else if (access) begin
            // memWrite wins when both controls are set
            memWB      <= 2'b00;
            dmem_req   <= 1'b1;
            dmem_we    <= memWrite;
            dmem_addr  <= AluResultOutput;
            dmem_wdata <= readData2Output;
            rd_q       <= rdORrtOutput;
            wb_q       <= WBoutput;
            cnt_q      <= '0;
            state_q    <= BUSY;
          end else begin
            memWB <= WBoutput;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            memReadData  <= dmem_we ? 32'd0 : dmem_rdata;
            memAluResult <= dmem_addr;
            memRd        <= rd_q;
            memWB        <= wb_q;
            state_q      <= IDLE;
          end else begin
            memWB       <= 2'b00;
            memReadData <= '0;
            if (last) begin
              dmem_req <= 1'b0;
              bus_err  <= 1'b1;
              state_q  <= IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
